// File: rtl/mem_pkg.sv
// Shared size encodings, FSM states and lane helpers for the memory access unit.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Sized for the widest bus; callers truncate to their own strobe width.
    function automatic logic [7:0] strobe(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] mask;
        case (size)
            SZ_BYTE: mask = 8'h01;
            SZ_HALF: mask = 8'h03;
            SZ_WORD: mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask << off;
    endfunction

    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] mask;
        case (size)
            SZ_BYTE: mask = 3'b000;
            SZ_HALF: mask = 3'b001;
            SZ_WORD: mask = 3'b011;
            default: mask = 3'b111;
        endcase
        return mask;
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] data, input logic [1:0] size,
                                           input logic sign);
        logic [63:0] res;
        case (size)
            SZ_BYTE: res = {{56{sign & data[7]}}, data[7:0]};
            SZ_HALF: res = {{48{sign & data[15]}}, data[15:0]};
            SZ_WORD: res = {{32{sign & data[31]}}, data[31:0]};
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational lane shift and sign/zero extension of raw bus read data.
module mem_load_align
    import mem_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  off,
    input  logic [1:0]        size,
    input  logic              sign,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;

    assign shifted = rdata >> {off, 3'b000};
    assign data    = DATA_W'(extend(64'(shifted), size, sign));

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle MEM stage: issues req/gnt/rvalid bus transfers, aligns data and
// flags misaligned accesses while holding the upstream pipeline.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int  DATA_W     = 32,
    parameter int  ADDR_W     = 32,
    parameter int  REG_ADDR_W = 5,
    localparam int STRB_W     = DATA_W / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_read,
    input  logic                  in_write,
    input  logic                  in_sign,
    input  logic [1:0]            in_size,
    input  logic [ADDR_W-1:0]     in_result,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic                  in_reg_we,
    input  logic [REG_ADDR_W-1:0] in_reg_addr,
    input  logic                  flush,
    output logic                  stall_req,
    output logic                  bus_req,
    output logic [STRB_W-1:0]     bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_reg_we,
    output logic [REG_ADDR_W-1:0] out_reg_addr,
    output logic                  exc_adel,
    output logic                  exc_ades,
    output logic [ADDR_W-1:0]     bad_vaddr
);

    localparam int OFF_W = $clog2(STRB_W);

    state_e                  state;
    logic [ADDR_W-1:0]       r_addr;
    logic [STRB_W-1:0]       r_strb;
    logic [DATA_W-1:0]       r_wdata;
    logic                    r_is_load;
    logic [1:0]              r_size;
    logic                    r_sign;
    logic                    r_reg_we;
    logic [REG_ADDR_W-1:0]   r_reg_addr;
    logic                    r_flushed;
    logic                    cooldown;

    logic                    is_mem;
    logic                    size_ok;
    logic                    misaligned;
    logic                    accept;
    logic                    start_mem;
    logic [OFF_W-1:0]        in_off;
    logic [DATA_W-1:0]       load_data;

    assign in_off     = in_result[OFF_W-1:0];
    assign is_mem     = in_read | in_write;
    assign size_ok    = (in_size != SZ_DWORD) || (DATA_W == 64);
    // A dword access on a 32-bit bus cannot be issued, so it is reported as an address error.
    assign misaligned = !size_ok || (|(in_result[2:0] & align_mask(in_size)));
    // The first IDLE cycle after a bus transfer still sees the held upstream op, so it is skipped.
    assign accept     = (state == ST_IDLE) && !cooldown && in_valid && !flush;
    assign start_mem  = accept && is_mem && !misaligned;
    assign stall_req  = start_mem || (state != ST_IDLE);

    assign bus_req    = (state == ST_REQ);
    assign bus_we     = bus_req ? r_strb : '0;
    assign bus_addr   = bus_req ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus_wdata  = bus_req ? r_wdata : '0;

    mem_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .rdata (bus_rdata),
        .off   (r_addr[OFF_W-1:0]),
        .size  (r_size),
        .sign  (r_sign),
        .data  (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            r_addr       <= '0;
            r_strb       <= '0;
            r_wdata      <= '0;
            r_is_load    <= 1'b0;
            r_size       <= SZ_BYTE;
            r_sign       <= 1'b0;
            r_reg_we     <= 1'b0;
            r_reg_addr   <= '0;
            r_flushed    <= 1'b0;
            cooldown     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_reg_we   <= 1'b0;
            out_reg_addr <= '0;
            exc_adel     <= 1'b0;
            exc_ades     <= 1'b0;
            bad_vaddr    <= '0;
        end else begin
            out_valid <= 1'b0;
            exc_adel  <= 1'b0;
            exc_ades  <= 1'b0;
            cooldown  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && !is_mem) begin
                        out_valid    <= 1'b1;
                        out_data     <= DATA_W'(in_result);
                        out_reg_we   <= in_reg_we;
                        out_reg_addr <= in_reg_addr;
                    end else if (accept && misaligned) begin
                        out_valid    <= 1'b1;
                        exc_adel     <= in_read;
                        exc_ades     <= in_write & ~in_read;
                        bad_vaddr    <= in_result;
                        out_reg_we   <= 1'b0;
                        out_reg_addr <= in_reg_addr;
                    end else if (start_mem) begin
                        state      <= ST_REQ;
                        r_addr     <= in_result;
                        r_strb     <= in_read ? '0 : STRB_W'(strobe(in_size, 3'(in_off)));
                        r_wdata    <= in_wdata << {in_off, 3'b000};
                        r_is_load  <= in_read;
                        r_size     <= in_size;
                        r_sign     <= in_sign;
                        r_reg_we   <= in_reg_we;
                        r_reg_addr <= in_reg_addr;
                        r_flushed  <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        if (r_is_load) begin
                            state     <= ST_RESP;
                            r_flushed <= flush;
                        end else begin
                            state    <= ST_IDLE;
                            cooldown <= 1'b1;
                            if (!flush) begin
                                out_valid    <= 1'b1;
                                out_data     <= DATA_W'(r_addr);
                                out_reg_we   <= r_reg_we;
                                out_reg_addr <= r_reg_addr;
                            end
                        end
                    end else if (flush) begin
                        state    <= ST_IDLE;
                        cooldown <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (bus_rvalid) begin
                        state    <= ST_IDLE;
                        cooldown <= 1'b1;
                        if (!(r_flushed || flush)) begin
                            out_valid    <= 1'b1;
                            out_data     <= load_data;
                            out_reg_we   <= r_reg_we;
                            out_reg_addr <= r_reg_addr;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
